// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream image loader driving the instruction-memory write port
module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  // Largest legal word count: exactly fills the memory.
  localparam logic [CNT_WIDTH:0] MAX_WORDS = (CNT_WIDTH+1)'(1) << ADDR_WIDTH;

  state_t                r_state;
  state_t                w_next;
  logic [CNT_WIDTH-1:0]  r_len;
  logic [CNT_WIDTH-1:0]  r_word_cnt;
  logic [1:0]            r_byte_idx;
  logic [23:0]           r_word;
  logic [7:0]            r_csum;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [31:0]           r_wr_data;

  logic                  w_xfer;
  logic                  w_restart;
  logic                  w_last_word;
  logic                  w_len_over;
  logic [CNT_WIDTH-1:0]  w_len;

  assign w_xfer      = in_valid && in_ready;
  assign w_restart   = start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
  // Full header value as it becomes known on the LEN_HI transfer.
  assign w_len       = {in_data, r_len[7:0]};
  assign w_len_over  = {1'b0, w_len} > MAX_WORDS;
  // The counter is compared against N-1 rather than used past the last word,
  // so a full-memory image never needs the wrapped counter as an address.
  assign w_last_word = (r_byte_idx == 2'd3) && (r_word_cnt == r_len - CNT_WIDTH'(1));

  assign in_ready = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                    (r_state == S_DATA) || (r_state == S_CSUM);
  assign done     = (r_state == S_DONE);
  assign error    = (r_state == S_ERR);
  assign cpu_hold = (r_state != S_DONE);
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state decode; the stream is never stalled so every ready state advances on valid.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_LEN0;
      S_LEN0:  if (w_xfer) w_next = S_LEN1;
      S_LEN1: begin
        if (w_xfer) begin
          if (w_len_over)      w_next = S_ERR;
          else if (w_len == 0) w_next = S_CSUM;
          else                 w_next = S_DATA;
        end
      end
      S_DATA:  if (w_xfer && w_last_word) w_next = S_CSUM;
      S_CSUM:  if (w_xfer) w_next = (in_data == r_csum) ? S_DONE : S_ERR;
      S_DONE:  if (start) w_next = S_LEN0;
      S_ERR:   if (start) w_next = S_LEN0;
      default: w_next = S_IDLE;
    endcase
  end

  // Header capture, little-endian word assembly, checksum and the one-cycle write strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len      <= '0;
      r_word_cnt <= '0;
      r_byte_idx <= '0;
      r_word     <= '0;
      r_csum     <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_restart) begin
        r_len      <= '0;
        r_word_cnt <= '0;
        r_byte_idx <= '0;
        r_csum     <= '0;
      end else if (w_xfer) begin
        case (r_state)
          S_LEN0: r_len[7:0] <= in_data;
          S_LEN1: r_len      <= w_len;
          S_DATA: begin
            r_csum     <= r_csum ^ in_data;
            r_byte_idx <= r_byte_idx + 2'd1;
            case (r_byte_idx)
              2'd0: r_word[7:0]   <= in_data;
              2'd1: r_word[15:8]  <= in_data;
              2'd2: r_word[23:16] <= in_data;
              default: begin
                r_wr_en    <= 1'b1;
                r_wr_addr  <= r_word_cnt[ADDR_WIDTH-1:0];
                r_wr_data  <= {in_data, r_word};
                r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [7:0]  wa[$];
  logic [31:0] wd[$];

  logic [7:0]  img1 [14] = '{8'h03, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93,
                             8'h00, 8'h10, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
  logic [7:0]  exp_a [3] = '{8'h00, 8'h01, 8'h02};
  logic [31:0] exp_d [3] = '{32'h00000013, 32'h00100093, 32'h0000006F};

  imem_loader #(.ADDR_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Record every write strobe seen away from the active edge.
  always @(negedge clk) begin
    if (rst && wr_en) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
  endtask

  task automatic fin;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_start;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_img1(input logic [7:0] cs, input int maxgap);
    for (int i = 0; i < 14; i++) send(img1[i], int'($urandom_range(0, maxgap)));
    send(cs, int'($urandom_range(0, maxgap)));
    fin();
  endtask

  task automatic chk_img1_writes(input string pfx);
    chk({pfx, "_nwr"}, 32'(wa.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_addr%0d", pfx, i), (i < wa.size()) ? 32'(wa[i]) : 32'hDEADBEEF, 32'(exp_a[i]));
      chk($sformatf("%s_data%0d", pfx, i), (i < wd.size()) ? wd[i] : 32'hDEADBEEF, exp_d[i]);
    end
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wr_en",    32'(wr_en),    32'd0);
    chk("rst_wr_addr",  32'(wr_addr),  32'd0);
    chk("rst_wr_data",  wr_data,       32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_error",    32'(error),    32'd0);
    #20;
    @(negedge clk);
    rst = 1'b1;

    // IDLE ignores valid bytes
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd0);
    chk("idle_done",     32'(done),     32'd0);
    in_valid = 1'b0;

    // Three-word image, correct checksum (XOR of payload = 0xFF)
    wa.delete(); wd.delete();
    do_start();
    chk("t1_ready_len0", 32'(in_ready), 32'd1);
    chk("t1_hold_len0",  32'(cpu_hold), 32'd1);
    send_img1(8'hFF, 0);
    chk_img1_writes("t1");
    chk("t1_done",     32'(done),     32'd1);
    chk("t1_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("t1_error",    32'(error),    32'd0);
    chk("t1_in_ready", 32'(in_ready), 32'd0);

    // Same image, bad checksum
    wa.delete(); wd.delete();
    do_start();
    send_img1(8'h1D, 0);
    chk_img1_writes("t2");
    chk("t2_error",    32'(error),    32'd1);
    chk("t2_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("t2_done",     32'(done),     32'd0);

    // Empty image
    wa.delete(); wd.delete();
    do_start();
    chk("t3_error_clr", 32'(error), 32'd0);
    send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    fin();
    chk("t3_nwr",  32'(wa.size()), 32'd0);
    chk("t3_done", 32'(done),      32'd1);

    // Oversized header N=257
    do_start();
    send(8'h01, 0); send(8'h01, 0);
    fin();
    chk("t4_error",    32'(error),    32'd1);
    chk("t4_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    chk("t4_nwr",   32'(wa.size()), 32'd0);
    chk("t4_error2", 32'(error),    32'd1);
    chk("t4_done",  32'(done),      32'd0);

    // Full-memory image N=256, word i = i; XOR of 0..255 is 0
    wa.delete(); wd.delete();
    do_start();
    send(8'h00, 0); send(8'h01, 0);
    for (int i = 0; i < 256; i++) begin
      send(8'(i), 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    end
    send(8'h00, 0);
    fin();
    chk("t5_nwr",    32'(wa.size()), 32'd256);
    chk("t5_addr0",  (wa.size() > 0)   ? 32'(wa[0])   : 32'hDEADBEEF, 32'h00);
    chk("t5_addr100", (wa.size() > 100) ? 32'(wa[100]) : 32'hDEADBEEF, 32'h64);
    chk("t5_data100", (wd.size() > 100) ? wd[100]      : 32'hDEADBEEF, 32'h64);
    chk("t5_addr255", (wa.size() > 255) ? 32'(wa[255]) : 32'hDEADBEEF, 32'hFF);
    chk("t5_data255", (wd.size() > 255) ? wd[255]      : 32'hDEADBEEF, 32'hFF);
    chk("t5_done",   32'(done), 32'd1);

    // First image with random valid gaps
    wa.delete(); wd.delete();
    do_start();
    send_img1(8'hFF, 3);
    chk_img1_writes("t6");
    chk("t6_done",  32'(done),  32'd1);
    chk("t6_error", 32'(error), 32'd0);

    // Asynchronous reset after six payload bytes
    wa.delete(); wd.delete();
    do_start();
    send(8'h02, 0); send(8'h00, 0);
    send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 0);
    send(8'h11, 0); send(8'h22, 0);
    @(posedge clk);
    #1;
    chk("t7_pre_wr_data", wr_data, 32'hDDCCBBAA);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("t7_in_ready", 32'(in_ready), 32'd0);
    chk("t7_wr_en",    32'(wr_en),    32'd0);
    chk("t7_wr_addr",  32'(wr_addr),  32'd0);
    chk("t7_wr_data",  wr_data,       32'd0);
    chk("t7_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("t7_done",     32'(done),     32'd0);
    chk("t7_error",    32'(error),    32'd0);
    @(negedge clk);
    rst = 1'b1;

    // One-word image after reset; checksum 78^56^34^12 = 08
    wa.delete(); wd.delete();
    do_start();
    send(8'h01, 0); send(8'h00, 0);
    send(8'h78, 0); send(8'h56, 0); send(8'h34, 0); send(8'h12, 0);
    send(8'h08, 0);
    fin();
    chk("t8_nwr",      32'(wa.size()), 32'd1);
    chk("t8_addr",     (wa.size() > 0) ? 32'(wa[0]) : 32'hDEADBEEF, 32'h00);
    chk("t8_data",     (wd.size() > 0) ? wd[0]      : 32'hDEADBEEF, 32'h12345678);
    chk("t8_done",     32'(done),     32'd1);
    chk("t8_cpu_hold", 32'(cpu_hold), 32'd0);

    // Restart from DONE
    do_start();
    chk("t9_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("t9_done",     32'(done),     32'd0);
    chk("t9_in_ready", 32'(in_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
